// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception/interrupt commit controller:
// ExcCodes, CP0 register indices, FSM states and the commit payload bundle.
package cp0_pkg;

    localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned BADVADDR = 8;
    localparam int unsigned STATUS   = 12;
    localparam int unsigned CAUSE    = 13;
    localparam int unsigned EPC      = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Registered CP0 write-side payload presented during COMMIT
    typedef struct packed {
        logic [31:0] we;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic [4:0]  exc_code;
        logic        bd;
        logic [1:0]  sw_int;
        logic [7:0]  int_en;
        logic        exl;
        logic        ie;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
    } commit_t;

    function automatic logic [31:0] reg_bit(input int unsigned idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// MEM-stage event inputs and CP0 write-side / pipeline-control outputs.
interface cp0_exception_ctrl_if;
    logic [5:0]  hw_int;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_ds;
    logic        exc_adel_if;
    logic        exc_ri;
    logic        exc_ov;
    logic        exc_sys;
    logic        exc_bp;
    logic        exc_adel_ld;
    logic        exc_ades;
    logic [31:0] mem_addr;
    logic        mem_eret;
    logic [31:0] status_in;
    logic [31:0] cause_in;
    logic [31:0] epc_in;

    logic [31:0] cp0_we;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_badvaddr;
    logic [4:0]  cp0_exc_code;
    logic        cp0_bd;
    logic [1:0]  cp0_sw_int;
    logic [5:0]  cp0_hw_int;
    logic [7:0]  cp0_int_en;
    logic        cp0_exl;
    logic        cp0_ie;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output hw_int, mem_valid, mem_pc, mem_in_ds, exc_adel_if, exc_ri, exc_ov,
               exc_sys, exc_bp, exc_adel_ld, exc_ades, mem_addr, mem_eret,
               status_in, cause_in, epc_in,
        input  cp0_we, cp0_epc, cp0_badvaddr, cp0_exc_code, cp0_bd, cp0_sw_int,
               cp0_hw_int, cp0_int_en, cp0_exl, cp0_ie, flush, stall,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  hw_int, mem_valid, mem_pc, mem_in_ds, exc_adel_if, exc_ri, exc_ov,
               exc_sys, exc_bp, exc_adel_ld, exc_ades, mem_addr, mem_eret,
               status_in, cause_in, epc_in,
        output cp0_we, cp0_epc, cp0_badvaddr, cp0_exc_code, cp0_bd, cp0_sw_int,
               cp0_hw_int, cp0_int_en, cp0_exl, cp0_ie, flush, stall,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/cp0_exception_ctrl_int_sync.sv
// Multi-flop synchroniser for the asynchronous external interrupt lines.
module int_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= async_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Prioritises MEM-stage exceptions, interrupts and ERET, then issues one-cycle
// CP0 write strobes, a pipeline flush and a PC redirect.
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DFLT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FLUSH_HOLD  = 1
) (
    input logic                  clk,
    input logic                  rst,
    cp0_exception_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((FLUSH_HOLD == 0) ? 0 : FLUSH_HOLD - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    commit_t           cmt_q, cmt_d;
    logic              flush_q, flush_d;
    logic [5:0]        sync_hw;

    logic              int_pend, is_exc, is_eret, addr_err, adel_if, evt;
    logic [4:0]        code;
    logic              unused_bits;

    int_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(6)) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.hw_int),
        .sync_out (sync_hw)
    );

    assign int_pend = bus.status_in[0] & ~bus.status_in[1] &
                      (|({sync_hw, bus.cause_in[9:8]} & bus.status_in[15:8]));

    // Event priority: Int > AdEL-IF > RI > Ov > Sys > Bp > AdEL-ld > AdES > ERET
    always_comb begin
        is_exc   = 1'b0;
        is_eret  = 1'b0;
        addr_err = 1'b0;
        adel_if  = 1'b0;
        code     = EXC_INT;
        if (bus.mem_valid) begin
            if (int_pend)             begin is_exc = 1'b1; code = EXC_INT; end
            else if (bus.exc_adel_if) begin is_exc = 1'b1; code = EXC_ADEL; addr_err = 1'b1; adel_if = 1'b1; end
            else if (bus.exc_ri)      begin is_exc = 1'b1; code = EXC_RI; end
            else if (bus.exc_ov)      begin is_exc = 1'b1; code = EXC_OV; end
            else if (bus.exc_sys)     begin is_exc = 1'b1; code = EXC_SYS; end
            else if (bus.exc_bp)      begin is_exc = 1'b1; code = EXC_BP; end
            else if (bus.exc_adel_ld) begin is_exc = 1'b1; code = EXC_ADEL; addr_err = 1'b1; end
            else if (bus.exc_ades)    begin is_exc = 1'b1; code = EXC_ADES; addr_err = 1'b1; end
            else if (bus.mem_eret)    begin is_eret = 1'b1; end
        end
    end

    assign evt = is_exc | is_eret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (evt) state_d = ST_COMMIT;
            ST_COMMIT: state_d = (FLUSH_HOLD > 0) ? ST_HOLD : ST_IDLE;
            ST_HOLD:   if (cnt_q == HOLD_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; payload exists only for COMMIT
    always_comb begin
        cmt_d   = '0;
        flush_d = (state_d != ST_IDLE);
        if (state_q == ST_IDLE && evt) begin
            cmt_d.int_en         = bus.status_in[15:8];
            cmt_d.ie             = bus.status_in[0];
            cmt_d.sw_int         = bus.cause_in[9:8];
            cmt_d.redirect_valid = 1'b1;
            if (is_exc) begin
                cmt_d.we = reg_bit(STATUS) | reg_bit(CAUSE);
                if (!bus.status_in[1]) cmt_d.we = cmt_d.we | reg_bit(EPC);
                if (addr_err)          cmt_d.we = cmt_d.we | reg_bit(BADVADDR);
                if (bus.status_in[1])  cmt_d.epc = bus.epc_in;
                else                   cmt_d.epc = bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
                cmt_d.bd          = bus.mem_in_ds & ~bus.status_in[1];
                cmt_d.badvaddr    = adel_if ? bus.mem_pc : bus.mem_addr;
                cmt_d.exc_code    = code;
                cmt_d.exl         = 1'b1;
                cmt_d.redirect_pc = EXC_VECTOR;
            end else begin
                cmt_d.we          = reg_bit(STATUS);
                cmt_d.exl         = 1'b0;
                cmt_d.redirect_pc = bus.epc_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmt_q   <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cmt_q   <= cmt_d;
            flush_q <= flush_d;
            cnt_q   <= (state_q == ST_HOLD) ? cnt_q + CNT_W'(1) : '0;
        end
    end

    assign bus.cp0_we         = cmt_q.we;
    assign bus.cp0_epc        = cmt_q.epc;
    assign bus.cp0_badvaddr   = cmt_q.badvaddr;
    assign bus.cp0_exc_code   = cmt_q.exc_code;
    assign bus.cp0_bd         = cmt_q.bd;
    assign bus.cp0_sw_int     = cmt_q.sw_int;
    assign bus.cp0_hw_int     = sync_hw;
    assign bus.cp0_int_en     = cmt_q.int_en;
    assign bus.cp0_exl        = cmt_q.exl;
    assign bus.cp0_ie         = cmt_q.ie;
    assign bus.flush          = flush_q;
    assign bus.stall          = flush_q;
    assign bus.redirect_valid = cmt_q.redirect_valid;
    assign bus.redirect_pc    = cmt_q.redirect_pc;

    assign unused_bits = ^{bus.status_in[31:16], bus.status_in[7:2],
                           bus.cause_in[31:10], bus.cause_in[7:0]};

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
Exception/interrupt commit controller that drives the CP0 register block's write side. It samples the MEM-stage instruction's exception flags and the ERET indication, synchronises external interrupt lines, and prioritises events. On the next cycle it emits one-cycle CP0 write strobes with payloads (EPC, BadVAddr, Cause, Status), a pipeline flush, and a PC redirect to the exception vector or to EPC.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions and interrupts
SYNC_STAGES, 2, flip-flop depth of the hw_int synchroniser (>=2)
FLUSH_HOLD, 1, cycles the flush/stall is held after the write cycle (0..7)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
hw_int  in  6  asynchronous external interrupt requests
mem_valid  in  1  MEM stage holds a real instruction
mem_pc  in  32  PC of the MEM instruction
mem_in_ds  in  1  MEM instruction sits in a branch delay slot
exc_adel_if  in  1  instruction fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_ld  in  1  load address error
exc_ades  in  1  store address error
mem_addr  in  32  data address of the MEM load/store
mem_eret  in  1  MEM instruction is ERET
status_in  in  32  current CP0 Status
cause_in  in  32  current CP0 Cause
epc_in  in  32  current CP0 EPC
cp0_we  out  32  one-hot-per-register write strobes (bit n = CP0 reg n)
cp0_epc  out  32  EPC write data
cp0_badvaddr  out  32  BadVAddr write data
cp0_exc_code  out  5  Cause.ExcCode write data
cp0_bd  out  1  Cause.BD write data
cp0_sw_int  out  2  Cause.IP[1:0] write data (copied from cause_in[9:8])
cp0_hw_int  out  6  synchronised hw_int, Cause.IP[7:2] write data
cp0_int_en  out  8  Status.IM write data (status_in[15:8])
cp0_exl  out  1  Status.EXL write data
cp0_ie  out  1  Status.IE write data (status_in[0])
flush  out  1  kill IF..MEM instructions
stall  out  1  freeze pipeline while controller is not IDLE
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  32  new fetch address

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. The synchroniser flops clear. Reset may assert in any state and aborts the sequence immediately; no partial strobe survives.
- hw_int passes through SYNC_STAGES flops. cp0_hw_int is always the last stage.
- Interrupt pending = status_in[0] & ~status_in[1] & |({sync_hw, cause_in[9:8]} & status_in[15:8]). It is taken only when mem_valid=1.
- Event detection happens in IDLE only, with mem_valid=1. Priority, highest first, with ExcCode:
  Int 0 > AdEL-IF 4 > RI 10 > Ov 12 > Sys 8 > Bp 9 > AdEL-load 4 > AdES 5 > ERET.
  ERET is ignored if any exception or interrupt is present in the same cycle.
- FSM states: IDLE, COMMIT, HOLD.
  IDLE -> COMMIT when an event is detected.
  COMMIT -> HOLD when FLUSH_HOLD > 0, otherwise -> IDLE.
  HOLD counts FLUSH_HOLD cycles, then -> IDLE.
  Outputs are registered, so the first strobe appears in the cycle after detection. Latency is 1 cycle.
- COMMIT, exception or interrupt (exactly one cycle):
  - cp0_we bits 12, 13, 14 set; bit 8 set only for AdEL-IF, AdEL-load or AdES.
  - cp0_epc = mem_in_ds ? mem_pc-4 : mem_pc (mod 2^32).
  - cp0_bd = mem_in_ds.
  - cp0_badvaddr = mem_pc for AdEL-IF, else mem_addr.
  - cp0_exl = 1. IE and IM are written back unchanged.
  - flush = 1, redirect_valid = 1, redirect_pc = EXC_VECTOR.
- If status_in[1] (EXL) is already 1 when an exception is taken, cp0_we[14] and cp0_bd stay 0 and EPC is preserved. Interrupts cannot occur in this case.
- COMMIT, ERET: cp0_we = only bit 12, cp0_exl = 0, flush = 1, redirect_valid = 1, redirect_pc = epc_in sampled at detection.
- stall = 1 in COMMIT and HOLD. flush = 1 in COMMIT and HOLD. cp0_we, cp0_exc_code and redirect_valid are nonzero only in COMMIT.
- MEM inputs are ignored outside IDLE. Events do not queue; the pipeline re-presents them.

Decomposition:
- Shared package cp0_pkg:
  - ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - CP0 register index constants (BADVADDR=8, STATUS=12, CAUSE=13, EPC=14).
  - FSM state enum.
  - EXC_VECTOR default.
- One sub-module, int_sync: a parameterised SYNC_STAGES-deep synchroniser, 6 bits wide, asynchronous reset.

Test Plan:
- Reset released, mem_valid=0 for 10 cycles -> all outputs 0, FSM IDLE, no strobes.
- exc_ov=1, mem_pc=32'h80001000, mem_in_ds=0 -> next cycle: cp0_we=32'h00007000, cp0_exc_code=12, cp0_epc=32'h80001000, cp0_exl=1, redirect_pc=32'hBFC00380, flush=1 for 1+FLUSH_HOLD cycles.
- exc_ades=1 and exc_sys=1, mem_in_ds=1, mem_pc=32'h80002004, mem_addr=32'h00000003 -> cp0_exc_code=8, cp0_we bit8=0, cp0_epc=32'h80002000, cp0_bd=1.
- AdEL-IF with mem_pc=32'h80000001 -> cp0_we=32'h00007100, cp0_badvaddr=32'h80000001, exc_code=4.
- status_in=32'h0000_0401, hw_int[0] raised -> after SYNC_STAGES+1 cycles with mem_valid=1: exc_code=0, cp0_hw_int=6'b000001. Repeat with status_in[1]=1 -> no event.
- mem_eret=1, epc_in=32'h8000_0040 -> cp0_we=32'h00001000, cp0_exl=0, redirect_pc=32'h80000040. ERET combined with exc_ri -> RI wins. Assert rst during HOLD -> all outputs 0 the same cycle.
